// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: tracks E0/F0 prefixes with a timeout, keeps a held-key
// vector for a programmable key table and queues every decoded event in a FIFO.
//
// state   | meaning
// IDLE    | no prefix pending, next plain byte is a make
// EXT     | E0 received, waiting for F0 or the code byte
// BRK     | F0 received, next byte is a break code
// EXT_BRK | E0 F0 received, next byte is an extended break code
module ps2_key_decoder #(
  parameter int                    NUM_KEYS    = 5,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES   = {9'h05A, 9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int                    FIFO_DEPTH  = 4,
  parameter int                    TIMEOUT_CYC = 50000
) (
  input  logic                Clock_i,
  input  logic                Reset_i,
  input  logic [7:0]          dato_i,
  input  logic                rx_done_tick_i,
  output logic [NUM_KEYS-1:0] key_held_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic [9:0]          evt_data_o,
  output logic                evt_valid_o,
  input  logic                evt_ready_i,
  output logic [7:0]          dout_o,
  output logic                overflow_o,
  output logic                timeout_o
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]   TC_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  state_t              state, state_nxt;
  logic [TW-1:0]       tmo_cnt;
  logic                evt_fire, evt_brk, evt_ext, tmo_fire;
  logic [NUM_KEYS-1:0] held_nxt, press_nxt, release_nxt;
  logic [9:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CNTW-1:0]     count;
  logic                full, pop, push_ok;

  always_comb begin
    state_nxt = state;
    evt_fire  = 1'b0;
    evt_brk   = 1'b0;
    evt_ext   = 1'b0;
    tmo_fire  = 1'b0;
    if (rx_done_tick_i) begin
      unique case (state)
        IDLE: begin
          if (dato_i == 8'hE0)      state_nxt = EXT;
          else if (dato_i == 8'hF0) state_nxt = BRK;
          else                      evt_fire  = 1'b1;
        end
        EXT: begin
          if (dato_i == 8'hF0) state_nxt = EXT_BRK;
          else if (dato_i != 8'hE0) begin
            evt_fire  = 1'b1;
            evt_ext   = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          evt_fire  = 1'b1;
          evt_brk   = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          evt_fire  = 1'b1;
          evt_brk   = 1'b1;
          evt_ext   = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TC_LAST) begin
      tmo_fire  = 1'b1;
      state_nxt = IDLE;
    end
  end

  // Every matching table entry updates, so duplicate codes drive several keys.
  always_comb begin
    held_nxt    = key_held_o;
    press_nxt   = '0;
    release_nxt = '0;
    if (evt_fire) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (KEY_CODES[9*k +: 9] == {evt_ext, dato_i}) begin
          if (evt_brk) begin
            release_nxt[k] = key_held_o[k];
            held_nxt[k]    = 1'b0;
          end else begin
            press_nxt[k] = ~key_held_o[k];
            held_nxt[k]  = 1'b1;
          end
        end
      end
    end
  end

  assign evt_valid_o = (count != '0);
  assign evt_data_o  = mem[rd_ptr];
  assign full        = (count == CNT_FULL);
  assign pop         = evt_valid_o & evt_ready_i;
  assign push_ok     = evt_fire & (~full | pop);

  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rx_done_tick_i || state_nxt == IDLE) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      key_held_o    <= '0;
      key_press_o   <= '0;
      key_release_o <= '0;
      dout_o        <= '0;
      overflow_o    <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      key_held_o    <= held_nxt;
      key_press_o   <= press_nxt;
      key_release_o <= release_nxt;
      overflow_o    <= evt_fire & full & ~pop;
      timeout_o     <= tmo_fire;
      if (evt_fire) dout_o <= dato_i;
    end
  end

  // When full, a simultaneous pop frees the head slot that wr_ptr also addresses.
  always_ff @(posedge Clock_i or negedge Reset_i) begin
    if (!Reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {evt_brk, evt_ext, dato_i};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized scoreboard bench for ps2_key_decoder against a byte-stream reference model.
module tb_ps2_key_decoder;

  localparam int NK    = 5;
  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  bit          clk = 1'b0;
  logic        rst_n;
  logic [7:0]  dato;
  logic        rx;
  logic        ready;
  logic [NK-1:0] held, press, rel;
  logic [9:0]  evt_data;
  logic        evt_valid;
  logic [7:0]  dout;
  logic        ovf, tmo;

  ps2_key_decoder #(
    .NUM_KEYS   (NK),
    .KEY_CODES  ({9'h05A, 9'h023, 9'h01B, 9'h01C, 9'h01D}),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .Clock_i       (clk),
    .Reset_i       (rst_n),
    .dato_i        (dato),
    .rx_done_tick_i(rx),
    .key_held_o    (held),
    .key_press_o   (press),
    .key_release_o (rel),
    .evt_data_o    (evt_data),
    .evt_valid_o   (evt_valid),
    .evt_ready_i   (ready),
    .dout_o        (dout),
    .overflow_o    (ovf),
    .timeout_o     (tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          en;
    bit [NK-1:0] held;
    bit [NK-1:0] press;
    bit [NK-1:0] rel;
    bit [7:0]    dout;
    bit          ovf;
    bit          tmo;
    bit          valid;
  } exp_t;

  exp_t cur, pend;
  int   n_chk = 0;
  int   n_pass = 0;

  // reference model state
  bit [8:0]    key_tab [NK] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h05A};
  bit          pfx, m_ext, m_brk;
  int          wait_cyc, mcount;
  bit [NK-1:0] m_held;
  bit [7:0]    m_dout;
  logic [9:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_held"},  32'(held), 0);
    chk({tag, "_press"}, 32'(press), 0);
    chk({tag, "_rel"},   32'(rel), 0);
    chk({tag, "_dout"},  32'(dout), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
    chk({tag, "_tmo"},   32'(tmo), 0);
    chk({tag, "_valid"}, 32'(evt_valid), 0);
    chk({tag, "_data"},  32'(evt_data), 0);
  endtask

  task automatic model_reset();
    pfx = 0; m_ext = 0; m_brk = 0;
    wait_cyc = 0; mcount = 0;
    m_held = '0; m_dout = '0;
    exp_q.delete();
    pend = '0;
  endtask

  // Expected outputs after the coming clock edge, from the byte-level protocol rules.
  task automatic model(input bit v, input bit [7:0] b, input bit r);
    bit fire, e_brk, e_ext, will_pop, push_ok;
    fire = 0; e_brk = 0; e_ext = 0;
    will_pop = r && (mcount > 0);
    pend.press = '0; pend.rel = '0; pend.ovf = 0; pend.tmo = 0;
    if (v) begin
      wait_cyc = 0;
      if (!pfx) begin
        if (b == 8'hE0)      begin pfx = 1; m_ext = 1; m_brk = 0; end
        else if (b == 8'hF0) begin pfx = 1; m_ext = 0; m_brk = 1; end
        else fire = 1;
      end else if (m_brk) begin
        fire = 1; e_brk = 1; e_ext = m_ext;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b != 8'hE0) begin
        fire = 1; e_ext = 1;
      end
    end else if (pfx) begin
      wait_cyc++;
      if (wait_cyc == TMO) begin
        pfx = 0; m_ext = 0; m_brk = 0; wait_cyc = 0; pend.tmo = 1;
      end
    end
    if (fire) begin
      pfx = 0; m_ext = 0; m_brk = 0;
      m_dout = b;
      for (int k = 0; k < NK; k++) begin
        if (key_tab[k] == {e_ext, b}) begin
          if (e_brk) begin pend.rel[k] = m_held[k]; m_held[k] = 0; end
          else begin pend.press[k] = !m_held[k]; m_held[k] = 1; end
        end
      end
      push_ok = (mcount < DEPTH) || will_pop;
      if (push_ok) begin
        exp_q.push_back({e_brk, e_ext, b});
        mcount++;
      end else pend.ovf = 1;
    end
    if (will_pop) mcount--;
    pend.held  = m_held;
    pend.dout  = m_dout;
    pend.valid = (mcount > 0);
    pend.en    = 1;
  endtask

  task automatic step(input bit v, input bit [7:0] b, input bit r);
    @(posedge clk);
    cur = pend;
    #1;
    rx    = v;
    dato  = v ? b : 8'($urandom);
    ready = r;
    model(v, b, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && mcount > 0; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    cur.en = 0;
    #2;
    rx = 0; ready = 0;
    rst_n = 0;
    #1;
    chk_zero("mid_rst");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cur.en) begin
        chk("key_held",  32'(held),      32'(cur.held));
        chk("key_press", 32'(press),     32'(cur.press));
        chk("key_rel",   32'(rel),       32'(cur.rel));
        chk("dout",      32'(dout),      32'(cur.dout));
        chk("overflow",  32'(ovf),       32'(cur.ovf));
        chk("timeout",   32'(tmo),       32'(cur.tmo));
        chk("evt_valid", 32'(evt_valid), 32'(cur.valid));
        if (evt_valid === 1'b1 && ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL evt_pop: got %0h expected no event", evt_data);
          end else begin
            chk("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  endtask

  int       sel;
  bit [7:0] rb;

  initial begin
    rst_n = 1; rx = 0; ready = 0; dato = 0;
    model_reset();
    cur = '0;
    fork
      monitor();
    join_none
    #3 rst_n = 0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #3 rst_n = 1;

    // make/break of key 0
    step(1, 8'h1D, 0); step(0, 8'h00, 0); step(1, 8'hF0, 0); step(1, 8'h1D, 0);
    idle(3); drain();

    // extended codes with no table match
    step(1, 8'hE0, 0); step(1, 8'h75, 0);
    step(1, 8'hE0, 0); step(1, 8'hF0, 0); step(1, 8'h75, 0);
    idle(2); drain();

    // typematic repeats
    step(1, 8'h23, 0); step(1, 8'h23, 0); step(1, 8'h23, 0);
    step(1, 8'hF0, 0); step(1, 8'h23, 0);
    idle(2); drain();

    // prefix timeout, then a byte landing on the terminal cycle, then E0 restart
    step(1, 8'hF0, 0); idle(TMO); step(1, 8'h1C, 0); idle(2);
    step(1, 8'hE0, 0); idle(TMO - 1); step(1, 8'h75, 0); idle(2);
    step(1, 8'hE0, 0); idle(TMO - 5); step(1, 8'hE0, 0); idle(TMO - 5);
    step(1, 8'h1D, 0); idle(2); drain();

    // FIFO full, overflow, push+pop while full, drain
    step(1, 8'h1D, 0); step(1, 8'h1C, 0); step(1, 8'h1B, 0);
    step(1, 8'h23, 0); step(1, 8'h5A, 0);
    step(1, 8'h33, 1);
    idle(1); drain();

    // asynchronous reset mid-prefix
    step(1, 8'h1D, 0); step(1, 8'hE0, 0); step(1, 8'hF0, 0);
    mid_reset();
    step(1, 8'h5A, 0); idle(2); drain();

    // randomized byte stream with random consumer back-pressure
    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(99);
      if (sel < 45) begin
        step(0, 8'h00, 1'($urandom_range(1)));
      end else begin
        sel = $urandom_range(99);
        if (sel < 20)      rb = 8'hE0;
        else if (sel < 38) rb = 8'hF0;
        else if (sel < 80) rb = key_tab[$urandom_range(NK - 1)][7:0];
        else               rb = 8'($urandom);
        step(1, rb, 1'($urandom_range(1)));
      end
      if ($urandom_range(199) == 0) idle(TMO + 2);
    end

    drain(); idle(2);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
